// File: rtl/hci_outstanding_source_v2.sv
// Credit-based HCI-Outstanding load streamer: 2D strided loads, realigned in-order stream.
// Optional macro HCI_OUTSTANDING_SOURCE_STALL_CNT_EN enables the request stall counter.
module hci_outstanding_source_v2 #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MISALIGNED      = 1,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TRANS_CNT       = 16,
  localparam int unsigned SDW = DATA_WIDTH - 32 * MISALIGNED,
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    req_start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [TRANS_CNT-1:0]    d0_len_i,
  input  logic [31:0]             d0_stride_i,
  input  logic [31:0]             d1_stride_i,
  input  logic [TRANS_CNT-1:0]    tot_len_i,
  output logic                    tcdm_req_valid_o,
  input  logic                    tcdm_req_ready_i,
  output logic [31:0]             tcdm_req_add_o,
  output logic                    tcdm_req_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_req_be_o,
  input  logic                    tcdm_resp_valid_i,
  output logic                    tcdm_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]   tcdm_resp_data_i,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  output logic [SDW-1:0]          stream_data_o,
  output logic [SDW/8-1:0]        stream_strb_o,
  output logic                    ready_start_o,
  output logic                    done_o,
  output logic [CW-1:0]           credits_o,
  output logic [31:0]             stall_cnt_o
);

  // state | meaning
  // IDLE  | waiting for req_start_i
  // ISSUE | generating addresses and issuing loads
  // DRAIN | all loads issued, streaming out remaining beats
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  localparam int unsigned PW  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned DCW = CW + 1;

  state_t state_q, state_d;

  logic [31:0]          addr_q, row_q;
  logic [TRANS_CNT-1:0] col_q, req_cnt_q, beat_cnt_q;
  logic [CW-1:0]        credits_q, ofs_cnt_q, dat_cnt_q;
  logic [DCW-1:0]       drop_cnt_q;
  logic [PW-1:0]        ofs_wr_q, ofs_rd_q, dat_wr_q, dat_rd_q;
  logic [1:0]           ofs_mem [MAX_OUTSTANDING];
  logic [SDW-1:0]       dat_mem [MAX_OUTSTANDING];
  logic                 start, req_fire, resp_fire, resp_push, resp_drop, pop;
  logic                 last_req, last_beat;
  logic [SDW-1:0]       resp_aligned;

  assign start            = (state_q == IDLE) && req_start_i && enable_i;
  assign tcdm_req_valid_o = (state_q == ISSUE) && (credits_q != '0) && enable_i;
  assign req_fire         = tcdm_req_valid_o && tcdm_req_ready_i;
  assign resp_fire        = tcdm_resp_valid_i && enable_i;
  // Responses to loads issued before a clear are discarded, oldest first.
  assign resp_drop        = resp_fire && (drop_cnt_q != '0);
  assign resp_push        = resp_fire && (drop_cnt_q == '0);
  assign stream_valid_o   = (dat_cnt_q != '0);
  assign pop              = stream_valid_o && stream_ready_i && enable_i;
  assign last_req         = (req_cnt_q == tot_len_i - TRANS_CNT'(1));
  assign last_beat        = (beat_cnt_q == tot_len_i - TRANS_CNT'(1));

  assign resp_aligned = SDW'(tcdm_resp_data_i >>
                             ((MISALIGNED != 0) ? {ofs_mem[ofs_rd_q], 3'b000} : 5'd0));

  assign tcdm_req_add_o    = {addr_q[31:2], 2'b00};
  assign tcdm_req_wen_o    = 1'b1;
  assign tcdm_req_be_o     = '0;
  assign tcdm_resp_ready_o = enable_i;
  assign stream_data_o     = dat_mem[dat_rd_q];
  assign stream_strb_o     = '1;
  assign ready_start_o     = (state_q == IDLE);
  assign credits_o         = credits_q;

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (req_fire && last_req) state_d = DRAIN;
      DRAIN:   if (pop && last_beat) begin
                 state_d = IDLE;
                 done_o  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        state_q <= IDLE;
    else if (clear_i)   state_q <= IDLE;
    else if (enable_i)  state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      req_cnt_q  <= '0;
      beat_cnt_q <= '0;
      credits_q  <= CW'(MAX_OUTSTANDING);
      ofs_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      ofs_wr_q   <= '0;
      ofs_rd_q   <= '0;
      dat_wr_q   <= '0;
      dat_rd_q   <= '0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      req_cnt_q  <= '0;
      beat_cnt_q <= '0;
      credits_q  <= CW'(MAX_OUTSTANDING);
      ofs_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      ofs_wr_q   <= '0;
      ofs_rd_q   <= '0;
      dat_wr_q   <= '0;
      dat_rd_q   <= '0;
      drop_cnt_q <= drop_cnt_q + DCW'(ofs_cnt_q) + DCW'(req_fire) - DCW'(resp_fire);
    end else if (enable_i) begin
      if (req_fire) begin
        req_cnt_q <= req_cnt_q + TRANS_CNT'(1);
        ofs_wr_q  <= ofs_wr_q + PW'(1);
        if (col_q == d0_len_i - TRANS_CNT'(1)) begin
          col_q  <= '0;
          row_q  <= row_q + d1_stride_i;
          addr_q <= row_q + d1_stride_i;
        end else begin
          col_q  <= col_q + TRANS_CNT'(1);
          addr_q <= addr_q + d0_stride_i;
        end
      end
      if (resp_push) begin
        ofs_rd_q <= ofs_rd_q + PW'(1);
        dat_wr_q <= dat_wr_q + PW'(1);
      end
      if (resp_drop) drop_cnt_q <= drop_cnt_q - DCW'(1);
      if (pop) begin
        dat_rd_q   <= dat_rd_q + PW'(1);
        beat_cnt_q <= beat_cnt_q + TRANS_CNT'(1);
      end
      ofs_cnt_q <= ofs_cnt_q + CW'(req_fire) - CW'(resp_push);
      dat_cnt_q <= dat_cnt_q + CW'(resp_push) - CW'(pop);
      credits_q <= credits_q - CW'(req_fire) + CW'(pop);
      if (start) begin
        addr_q     <= base_addr_i;
        row_q      <= base_addr_i;
        col_q      <= '0;
        req_cnt_q  <= '0;
        beat_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enable_i && !clear_i) begin
      if (req_fire)  ofs_mem[ofs_wr_q] <= addr_q[1:0];
      if (resp_push) dat_mem[dat_wr_q] <= resp_aligned;
    end
  end

`ifdef HCI_OUTSTANDING_SOURCE_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 stall_q <= '0;
    else if (clear_i || start)   stall_q <= '0;
    else if (tcdm_req_valid_o && !tcdm_req_ready_i && stall_q != '1)
                                 stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credits_q <= CW'(MAX_OUTSTANDING));
  a_resp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_fire |-> (ofs_cnt_q != '0 || drop_cnt_q != '0));

endmodule
